sodor_mem_responder: RTL and testbench

//  Memory-side responder for the Sodor core/debug memory request/response protocol.

---
 rtl/sodor_mem_responder_if.sv | 46 ++++
 rtl/sodor_mem_responder.sv | 172 +++++++++++++++++
 tb/tb_sodor_mem_responder.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sodor_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : sodor_mem_responder_if
//  Brief    : Core + debug request/response bundle between Sodor requesters
//             and the scratchpad memory responder.
//  Revision : 1.0  initial release
// ============================================================================

interface sodor_mem_responder_if;
    logic        core_req_valid;
    logic        core_req_ready;
    logic [31:0] core_req_bits_addr;
    logic [31:0] core_req_bits_data;
    logic        core_req_bits_fcn;
    logic [2:0]  core_req_bits_typ;
    logic        core_resp_valid;
    logic [31:0] core_resp_bits_data;
    logic        debug_req_valid;
    logic [31:0] debug_req_bits_addr;
    logic [31:0] debug_req_bits_data;
    logic        debug_req_bits_fcn;
    logic [2:0]  debug_req_bits_typ;
    logic        debug_resp_valid;
    logic [31:0] debug_resp_bits_data;
    logic        misalign_err;

    modport master (
        output core_req_valid, core_req_bits_addr, core_req_bits_data,
               core_req_bits_fcn, core_req_bits_typ,
               debug_req_valid, debug_req_bits_addr, debug_req_bits_data,
               debug_req_bits_fcn, debug_req_bits_typ,
        input  core_req_ready, core_resp_valid, core_resp_bits_data,
               debug_resp_valid, debug_resp_bits_data, misalign_err
    );

    modport slave (
        input  core_req_valid, core_req_bits_addr, core_req_bits_data,
               core_req_bits_fcn, core_req_bits_typ,
               debug_req_valid, debug_req_bits_addr, debug_req_bits_data,
               debug_req_bits_fcn, debug_req_bits_typ,
        output core_req_ready, core_resp_valid, core_resp_bits_data,
               debug_resp_valid, debug_resp_bits_data, misalign_err
    );
endinterface

`default_nettype wire

// File: rtl/sodor_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : sodor_mem_responder
//  Brief    : Fixed-latency scratchpad responder for one core port and one
//             debug port; debug wins arbitration.
//  Revision : 1.0  initial release
// ============================================================================

module sodor_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  wire logic            clock,
    input  wire logic            reset,
    sodor_mem_responder_if.slave bus
);

    localparam int         c_ADDR_W = $clog2(DEPTH_WORDS);
    localparam logic [2:0] c_TYP_B  = 3'd1;
    localparam logic [2:0] c_TYP_H  = 3'd2;
    localparam logic [2:0] c_TYP_W  = 3'd3;
    localparam logic [2:0] c_TYP_BU = 3'd5;
    localparam logic [2:0] c_TYP_HU = 3'd6;

    logic                w_dbg_acc;
    logic                w_core_acc;
    logic                w_acc;
    logic [31:0]         w_addr;
    logic [31:0]         w_data;
    logic                w_fcn;
    logic [2:0]          w_typ;
    logic [c_ADDR_W-1:0] w_idx;
    logic [1:0]          w_lane;
    logic                w_bad;
    logic                w_we;
    logic [3:0]          w_be;
    logic [31:0]         w_wdata;

    logic [31:0]         r_mem [DEPTH_WORDS];
    logic [31:0]         r_rd_word;

    logic                r_s0_v;
    logic                r_s0_port;
    logic                r_s0_rd_ok;
    logic [2:0]          r_s0_typ;
    logic [1:0]          r_s0_lane;
    logic                r_misalign;

    logic [31:0]         w_lane_word;
    logic [31:0]         w_fmt;

    logic [LATENCY-1:0]  r_p_v;
    logic [LATENCY-1:0]  r_p_port;
    logic [31:0]         r_p_data [LATENCY];

    assign bus.core_req_ready = !bus.debug_req_valid;

    always_comb begin
        w_dbg_acc  = bus.debug_req_valid;
        w_core_acc = bus.core_req_valid && !bus.debug_req_valid;
        w_acc      = w_dbg_acc || w_core_acc;
        if (w_dbg_acc) begin
            w_addr = bus.debug_req_bits_addr;
            w_data = bus.debug_req_bits_data;
            w_fcn  = bus.debug_req_bits_fcn;
            w_typ  = bus.debug_req_bits_typ;
        end else begin
            w_addr = bus.core_req_bits_addr;
            w_data = bus.core_req_bits_data;
            w_fcn  = bus.core_req_bits_fcn;
            w_typ  = bus.core_req_bits_typ;
        end
        // Address bits above the array size are dropped, so accesses wrap.
        w_idx   = c_ADDR_W'(w_addr >> 2);
        w_lane  = w_addr[1:0];
        w_bad   = 1'b0;
        w_be    = 4'b0000;
        w_wdata = w_data;
        case (w_typ)
            c_TYP_B, c_TYP_BU: begin
                w_be    = 4'b0001 << w_lane;
                w_wdata = {4{w_data[7:0]}};
            end
            c_TYP_H, c_TYP_HU: begin
                w_bad   = w_lane[0];
                w_be    = 4'b0011 << {w_lane[1], 1'b0};
                w_wdata = {2{w_data[15:0]}};
            end
            c_TYP_W: begin
                w_bad = |w_lane;
                w_be  = 4'b1111;
            end
            default: w_bad = 1'b1;
        endcase
        w_we = w_acc && w_fcn && !w_bad;
    end

    // Storage is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (w_we && w_be[b]) begin
                r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
            end
        end
        if (w_acc && !w_fcn) begin
            r_rd_word <= r_mem[w_idx];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s0_v     <= 1'b0;
            r_s0_port  <= 1'b0;
            r_s0_rd_ok <= 1'b0;
            r_s0_typ   <= 3'd0;
            r_s0_lane  <= 2'd0;
            r_misalign <= 1'b0;
        end else begin
            r_s0_v     <= w_acc;
            r_s0_port  <= w_dbg_acc;
            r_s0_rd_ok <= w_acc && !w_fcn && !w_bad;
            r_s0_typ   <= w_typ;
            r_s0_lane  <= w_lane;
            if (w_acc && w_bad) begin
                r_misalign <= 1'b1;
            end
        end
    end

    // Writes and rejected requests answer with zero data.
    always_comb begin
        w_lane_word = r_rd_word >> {r_s0_lane, 3'b000};
        w_fmt       = '0;
        if (r_s0_rd_ok) begin
            case (r_s0_typ)
                c_TYP_B:  w_fmt = {{24{w_lane_word[7]}}, w_lane_word[7:0]};
                c_TYP_BU: w_fmt = {24'd0, w_lane_word[7:0]};
                c_TYP_H:  w_fmt = {{16{w_lane_word[15]}}, w_lane_word[15:0]};
                c_TYP_HU: w_fmt = {16'd0, w_lane_word[15:0]};
                default:  w_fmt = w_lane_word;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_p_v    <= '0;
            r_p_port <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_p_data[i] <= '0;
            end
        end else begin
            r_p_v[0]    <= r_s0_v;
            r_p_port[0] <= r_s0_port;
            r_p_data[0] <= w_fmt;
            for (int i = 1; i < LATENCY; i++) begin
                r_p_v[i]    <= r_p_v[i-1];
                r_p_port[i] <= r_p_port[i-1];
                r_p_data[i] <= r_p_data[i-1];
            end
        end
    end

    assign bus.core_resp_valid      = r_p_v[LATENCY-1] && !r_p_port[LATENCY-1];
    assign bus.debug_resp_valid     = r_p_v[LATENCY-1] &&  r_p_port[LATENCY-1];
    assign bus.core_resp_bits_data  = bus.core_resp_valid  ? r_p_data[LATENCY-1] : 32'd0;
    assign bus.debug_resp_bits_data = bus.debug_resp_valid ? r_p_data[LATENCY-1] : 32'd0;
    assign bus.misalign_err         = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_sodor_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sodor_mem_responder
//  Brief    : Drives a LATENCY=1 and a LATENCY=3 responder with identical
//             stimulus and checks both against a byte-array reference model.
//  Revision : 1.0  initial release
// ============================================================================

module tb_sodor_mem_responder;

    localparam int NC = 2048;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        cv = 1'b0, dv = 1'b0, cf = 1'b0, df = 1'b0;
    logic [31:0] ca = '0, cd = '0, da = '0, dd = '0;
    logic [2:0]  ct = 3'd0, dt = 3'd0;

    sodor_mem_responder_if bus1 ();
    sodor_mem_responder_if bus3 ();

    assign bus1.core_req_valid      = cv;  assign bus3.core_req_valid      = cv;
    assign bus1.core_req_bits_addr  = ca;  assign bus3.core_req_bits_addr  = ca;
    assign bus1.core_req_bits_data  = cd;  assign bus3.core_req_bits_data  = cd;
    assign bus1.core_req_bits_fcn   = cf;  assign bus3.core_req_bits_fcn   = cf;
    assign bus1.core_req_bits_typ   = ct;  assign bus3.core_req_bits_typ   = ct;
    assign bus1.debug_req_valid     = dv;  assign bus3.debug_req_valid     = dv;
    assign bus1.debug_req_bits_addr = da;  assign bus3.debug_req_bits_addr = da;
    assign bus1.debug_req_bits_data = dd;  assign bus3.debug_req_bits_data = dd;
    assign bus1.debug_req_bits_fcn  = df;  assign bus3.debug_req_bits_fcn  = df;
    assign bus1.debug_req_bits_typ  = dt;  assign bus3.debug_req_bits_typ  = dt;

    sodor_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset), .bus(bus1.slave));
    sodor_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_dut3 (
        .clock(clock), .reset(reset), .bus(bus3.slave));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Streams: 0 core/L1, 1 debug/L1, 2 core/L3, 3 debug/L3; indexed by edge number.
    logic        got_v [0:3][0:NC-1];
    logic [31:0] got_d [0:3][0:NC-1];
    bit          exp_v [0:3][0:NC-1];
    bit   [31:0] exp_d [0:3][0:NC-1];

    logic [7:0]  mb [0:4095];
    bit          m_err = 1'b0;

    always begin
        @(posedge clock);
        cyc = cyc + 1;
        #1;
        if (cyc < NC) begin
            got_v[0][cyc] = bus1.core_resp_valid;  got_d[0][cyc] = bus1.core_resp_bits_data;
            got_v[1][cyc] = bus1.debug_resp_valid; got_d[1][cyc] = bus1.debug_resp_bits_data;
            got_v[2][cyc] = bus3.core_resp_valid;  got_d[2][cyc] = bus3.core_resp_bits_data;
            got_v[3][cyc] = bus3.debug_resp_valid; got_d[3][cyc] = bus3.debug_resp_bits_data;
        end
    end

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] d,
                                          input logic f, input logic [2:0] t);
        int size; bit sgn; int base; logic [31:0] r;
        size = 0; sgn = 1'b0;
        case (t)
            3'd1: begin size = 1; sgn = 1'b1; end
            3'd2: begin size = 2; sgn = 1'b1; end
            3'd3: size = 4;
            3'd5: size = 1;
            3'd6: size = 2;
            default: size = 0;
        endcase
        if (size == 0 || (int'(a[1:0]) % size) != 0) begin
            m_err = 1'b1;
            return 32'h0;
        end
        base = int'((a >> 2) % 1024) * 4 + int'(a[1:0]);
        if (f) begin
            for (int k = 0; k < size; k++) mb[base+k] = d[8*k +: 8];
            return 32'h0;
        end
        r = '0;
        for (int k = 0; k < size; k++) r[8*k +: 8] = mb[base+k];
        if (sgn && r[8*size-1])
            for (int k = size; k < 4; k++) r[8*k +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic push_exp(input int port, input int e, input logic [31:0] r);
        if (e + 3 < NC) begin
            exp_v[port][e+1]   = 1'b1; exp_d[port][e+1]   = r;
            exp_v[port+2][e+3] = 1'b1; exp_d[port+2][e+3] = r;
        end
    endtask

    task automatic step();
        int e; logic [31:0] r;
        e = cyc + 1;
        if (dv) begin
            r = model(da, dd, df, dt); push_exp(1, e, r);
        end else if (cv) begin
            r = model(ca, cd, cf, ct); push_exp(0, e, r);
        end
        @(posedge clock); #1;
    endtask

    task automatic idle(input int n);
        cv = 1'b0; dv = 1'b0;
        repeat (n) step();
    endtask

    task automatic core_req(input logic f, input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
        cv = 1'b1; cf = f; ct = t; ca = a; cd = d; dv = 1'b0;
    endtask

    task automatic test_reset();
        int c0;
        #1 reset = 1'b0;
        dv = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if ({bus1.core_resp_valid, bus1.debug_resp_valid, bus3.core_resp_valid, bus3.debug_resp_valid} !== 4'b0) begin
            bad++; $display("FAIL reset_valid got=%b want=0000", {bus1.core_resp_valid, bus1.debug_resp_valid, bus3.core_resp_valid, bus3.debug_resp_valid});
        end
        total++;
        if ({bus1.core_resp_bits_data, bus1.debug_resp_bits_data, bus3.core_resp_bits_data, bus3.debug_resp_bits_data} !== 128'd0) begin
            bad++; $display("FAIL reset_data got=%h %h want=0", bus1.core_resp_bits_data, bus3.core_resp_bits_data);
        end
        total++;
        if ({bus1.misalign_err, bus3.misalign_err} !== 2'b00) begin
            bad++; $display("FAIL reset_err got=%b%b want=00", bus1.misalign_err, bus3.misalign_err);
        end
        total++;
        if ({bus1.core_req_ready, bus3.core_req_ready} !== 2'b00) begin
            bad++; $display("FAIL ready_dbg_busy got=%b%b want=00", bus1.core_req_ready, bus3.core_req_ready);
        end
        dv = 1'b0;
        #1;
        total++;
        if ({bus1.core_req_ready, bus3.core_req_ready} !== 2'b11) begin
            bad++; $display("FAIL ready_dbg_idle got=%b%b want=11", bus1.core_req_ready, bus3.core_req_ready);
        end
        reset = 1'b1;
        c0 = cyc;
        // Seed words 0..31 through the debug port so later reads are defined.
        for (int w = 0; w < 32; w++) begin
            dv = 1'b1; df = 1'b1; dt = 3'd3; da = 32'(w) << 2; dd = $urandom;
            step();
        end
        idle(4);
        for (int c = c0; c < cyc; c++) for (int s = 0; s < 4; s++) begin
            total++;
            if (got_v[s][c] !== exp_v[s][c] || (exp_v[s][c] && got_d[s][c] !== exp_d[s][c])) begin
                bad++; $display("FAIL init_resp s=%0d cyc=%0d got v=%b d=%h want v=%b d=%h", s, c, got_v[s][c], got_d[s][c], exp_v[s][c], exp_d[s][c]);
            end
        end
    endtask

    task automatic test_basic();
        int c0, e0;
        c0 = cyc; e0 = cyc + 1;
        core_req(1'b1, 3'd3, 32'h10, 32'hDEADBEEF); step();
        core_req(1'b0, 3'd3, 32'h10, 32'h0);        step();
        idle(4);
        total++;
        if (got_v[0][e0+1] !== 1'b1 || got_d[0][e0+1] !== 32'h0 || got_v[0][e0+2] !== 1'b1 || got_d[0][e0+2] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL basic_rw got v=%b%b d=%h want v=11 d=deadbeef", got_v[0][e0+1], got_v[0][e0+2], got_d[0][e0+2]);
        end
        for (int c = c0; c < cyc; c++) for (int s = 0; s < 4; s++) begin
            total++;
            if (got_v[s][c] !== exp_v[s][c] || (exp_v[s][c] && got_d[s][c] !== exp_d[s][c])) begin
                bad++; $display("FAIL basic_resp s=%0d cyc=%0d got v=%b d=%h want v=%b d=%h", s, c, got_v[s][c], got_d[s][c], exp_v[s][c], exp_d[s][c]);
            end
        end
    endtask

    task automatic test_bytes();
        int c0, e0;
        logic [31:0] want [0:2];
        want[0] = 32'hFFFFFF80; want[1] = 32'h00000080; want[2] = 32'h80ADBEEF;
        c0 = cyc; e0 = cyc + 1;
        core_req(1'b1, 3'd1, 32'h13, 32'h80); step();
        core_req(1'b0, 3'd1, 32'h13, 32'h0);  step();
        core_req(1'b0, 3'd5, 32'h13, 32'h0);  step();
        core_req(1'b0, 3'd3, 32'h10, 32'h0);  step();
        idle(4);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (got_v[0][e0+2+k] !== 1'b1 || got_d[0][e0+2+k] !== want[k] || got_v[2][e0+4+k] !== 1'b1 || got_d[2][e0+4+k] !== want[k]) begin
                bad++; $display("FAIL bytes_read k=%0d got L1=%h L3=%h want %h", k, got_d[0][e0+2+k], got_d[2][e0+4+k], want[k]);
            end
        end
        for (int c = c0; c < cyc; c++) for (int s = 0; s < 4; s++) begin
            total++;
            if (got_v[s][c] !== exp_v[s][c] || (exp_v[s][c] && got_d[s][c] !== exp_d[s][c])) begin
                bad++; $display("FAIL bytes_resp s=%0d cyc=%0d got v=%b d=%h want v=%b d=%h", s, c, got_v[s][c], got_d[s][c], exp_v[s][c], exp_d[s][c]);
            end
        end
    endtask

    task automatic test_priority();
        int c0, e1;
        c0 = cyc;
        core_req(1'b0, 3'd3, 32'h10, 32'h0);
        dv = 1'b1; df = 1'b0; dt = 3'd5; da = 32'h13;
        #1;
        total++;
        if ({bus1.core_req_ready, bus3.core_req_ready} !== 2'b00) begin
            bad++; $display("FAIL prio_ready_held got=%b%b want=00", bus1.core_req_ready, bus3.core_req_ready);
        end
        e1 = cyc + 1;
        step();
        dv = 1'b0;
        #1;
        total++;
        if ({bus1.core_req_ready, bus3.core_req_ready} !== 2'b11) begin
            bad++; $display("FAIL prio_ready_free got=%b%b want=11", bus1.core_req_ready, bus3.core_req_ready);
        end
        step();
        idle(4);
        total++;
        if (got_v[1][e1+1] !== 1'b1 || got_d[1][e1+1] !== 32'h80 || got_v[0][e1+1] !== 1'b0 || got_v[0][e1+2] !== 1'b1 || got_d[0][e1+2] !== 32'h80ADBEEF) begin
            bad++; $display("FAIL prio_order got dbg=%b/%h core=%b%b/%h want dbg=1/80 core=01/80adbeef", got_v[1][e1+1], got_d[1][e1+1], got_v[0][e1+1], got_v[0][e1+2], got_d[0][e1+2]);
        end
        for (int c = c0; c < cyc; c++) for (int s = 0; s < 4; s++) begin
            total++;
            if (got_v[s][c] !== exp_v[s][c] || (exp_v[s][c] && got_d[s][c] !== exp_d[s][c])) begin
                bad++; $display("FAIL prio_resp s=%0d cyc=%0d got v=%b d=%h want v=%b d=%h", s, c, got_v[s][c], got_d[s][c], exp_v[s][c], exp_d[s][c]);
            end
        end
    endtask

    task automatic test_misalign();
        int c0, e0;
        total++;
        if ({bus1.misalign_err, bus3.misalign_err} !== 2'b00) begin
            bad++; $display("FAIL err_pre got=%b%b want=00", bus1.misalign_err, bus3.misalign_err);
        end
        c0 = cyc; e0 = cyc + 1;
        core_req(1'b0, 3'd2, 32'h11, 32'h0);    step();
        total++;
        if ({bus1.misalign_err, bus3.misalign_err} !== 2'b11) begin
            bad++; $display("FAIL err_set got=%b%b want=11", bus1.misalign_err, bus3.misalign_err);
        end
        core_req(1'b1, 3'd2, 32'h11, 32'h1234); step();
        core_req(1'b1, 3'd4, 32'h10, 32'h5555); step();
        core_req(1'b0, 3'd3, 32'h10, 32'h0);    step();
        idle(4);
        total++;
        if (got_v[0][e0+1] !== 1'b1 || got_d[0][e0+1] !== 32'h0 || got_v[2][e0+3] !== 1'b1 || got_d[2][e0+3] !== 32'h0) begin
            bad++; $display("FAIL err_resp got L1=%b/%h L3=%b/%h want 1/0", got_v[0][e0+1], got_d[0][e0+1], got_v[2][e0+3], got_d[2][e0+3]);
        end
        total++;
        if (got_d[0][e0+4] !== 32'h80ADBEEF) begin
            bad++; $display("FAIL err_nowrite got=%h want=80adbeef", got_d[0][e0+4]);
        end
        total++;
        if ({bus1.misalign_err, bus3.misalign_err} !== 2'b11) begin
            bad++; $display("FAIL err_sticky got=%b%b want=11", bus1.misalign_err, bus3.misalign_err);
        end
        for (int c = c0; c < cyc; c++) for (int s = 0; s < 4; s++) begin
            total++;
            if (got_v[s][c] !== exp_v[s][c] || (exp_v[s][c] && got_d[s][c] !== exp_d[s][c])) begin
                bad++; $display("FAIL err_stream s=%0d cyc=%0d got v=%b d=%h want v=%b d=%h", s, c, got_v[s][c], got_d[s][c], exp_v[s][c], exp_d[s][c]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c0, e0;
        c0 = cyc; e0 = cyc + 1;
        for (int k = 0; k < 4; k++) begin
            core_req(1'b0, 3'd3, 32'(k) << 2, 32'h0); step();
        end
        idle(5);
        total++;
        if (got_v[2][e0+2] !== 1'b0 || {got_v[2][e0+3], got_v[2][e0+4], got_v[2][e0+5], got_v[2][e0+6]} !== 4'b1111 || got_v[2][e0+7] !== 1'b0) begin
            bad++; $display("FAIL b2b_train got=%b%b%b%b%b%b want=011110", got_v[2][e0+2], got_v[2][e0+3], got_v[2][e0+4], got_v[2][e0+5], got_v[2][e0+6], got_v[2][e0+7]);
        end
        for (int c = c0; c < cyc; c++) for (int s = 0; s < 4; s++) begin
            total++;
            if (got_v[s][c] !== exp_v[s][c] || (exp_v[s][c] && got_d[s][c] !== exp_d[s][c])) begin
                bad++; $display("FAIL b2b_resp s=%0d cyc=%0d got v=%b d=%h want v=%b d=%h", s, c, got_v[s][c], got_d[s][c], exp_v[s][c], exp_d[s][c]);
            end
        end
    endtask

    task automatic test_inflight_reset();
        int c0, r_edge, e0;
        c0 = cyc;
        core_req(1'b0, 3'd3, 32'h10, 32'h0); step();
        core_req(1'b0, 3'd1, 32'h13, 32'h0); step();
        cv = 1'b0;
        #1 reset = 1'b0;
        r_edge = cyc;
        // Anything not yet delivered at the reset point must never appear.
        for (int c = r_edge + 1; c < NC; c++) for (int s = 0; s < 4; s++) exp_v[s][c] = 1'b0;
        m_err = 1'b0;
        #1;
        total++;
        if ({bus1.misalign_err, bus3.misalign_err, bus1.core_resp_valid, bus3.core_resp_valid} !== 4'b0) begin
            bad++; $display("FAIL rst_async got err=%b%b v=%b%b want 0", bus1.misalign_err, bus3.misalign_err, bus1.core_resp_valid, bus3.core_resp_valid);
        end
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        idle(5);
        e0 = cyc + 1;
        core_req(1'b0, 3'd3, 32'h10, 32'h0); step();
        idle(4);
        total++;
        if (got_d[0][e0+1] !== 32'h80ADBEEF || got_d[2][e0+3] !== 32'h80ADBEEF) begin
            bad++; $display("FAIL rst_mem_kept got L1=%h L3=%h want 80adbeef", got_d[0][e0+1], got_d[2][e0+3]);
        end
        total++;
        if ({bus1.misalign_err, bus3.misalign_err} !== 2'b00) begin
            bad++; $display("FAIL rst_err got=%b%b want=00", bus1.misalign_err, bus3.misalign_err);
        end
        for (int c = c0; c < cyc; c++) for (int s = 0; s < 4; s++) begin
            total++;
            if (got_v[s][c] !== exp_v[s][c] || (exp_v[s][c] && got_d[s][c] !== exp_d[s][c])) begin
                bad++; $display("FAIL rst_resp s=%0d cyc=%0d got v=%b d=%h want v=%b d=%h", s, c, got_v[s][c], got_d[s][c], exp_v[s][c], exp_d[s][c]);
            end
        end
    endtask

    task automatic test_random();
        int c0;
        bit held;
        c0 = cyc;
        held = 1'b0;
        cv = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!held) begin
                cv = 1'($urandom_range(0, 1));
                ca = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
                cd = $urandom; cf = 1'($urandom_range(0, 1)); ct = 3'($urandom_range(0, 7));
            end
            dv = ($urandom_range(0, 3) == 0);
            da = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            dd = $urandom; df = 1'($urandom_range(0, 1)); dt = 3'($urandom_range(0, 7));
            #1;
            total++;
            if (bus1.core_req_ready !== !dv || bus3.core_req_ready !== !dv) begin
                bad++; $display("FAIL rand_ready i=%0d got=%b%b want=%b", i, bus1.core_req_ready, bus3.core_req_ready, !dv);
            end
            held = cv && dv;
            step();
            total++;
            if (bus1.misalign_err !== m_err || bus3.misalign_err !== m_err) begin
                bad++; $display("FAIL rand_err i=%0d got=%b%b want=%b", i, bus1.misalign_err, bus3.misalign_err, m_err);
            end
        end
        idle(5);
        for (int c = c0; c < cyc; c++) for (int s = 0; s < 4; s++) begin
            total++;
            if (got_v[s][c] !== exp_v[s][c] || (exp_v[s][c] && got_d[s][c] !== exp_d[s][c])) begin
                bad++; $display("FAIL rand_resp s=%0d cyc=%0d got v=%b d=%h want v=%b d=%h", s, c, got_v[s][c], got_d[s][c], exp_v[s][c], exp_d[s][c]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bytes();
        test_priority();
        test_misalign();
        test_back_to_back();
        test_inflight_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
